// File: rtl/scan_val_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_val_pkg
//  Purpose  : Shared types and constants for the scan_validator wrapper.
//             - scan_state_e : validation FSM state encoding
//             - DONE_OFS / TIMEOUT_OFS : positions of the status flags in the
//               captured result, counted upward from the data MSB
//               (DONE_BIT = OUT_W, TIMEOUT_BIT = OUT_W+1).
//  Revision : 1.0  initial release
// ============================================================================
package scan_val_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4,
        S_UNLOAD  = 3'd5
    } scan_state_e;

    // Flag positions above the data MSB (OUT_W-1) inside the output chain.
    localparam int DONE_OFS    = 1;
    localparam int TIMEOUT_OFS = 2;

endpackage : scan_val_pkg
`default_nettype wire

// File: rtl/scan_misr.sv
`default_nettype none
// ============================================================================
//  Module   : scan_misr
//  Purpose  : W-bit multiple-input signature register. Rotates left by one
//             and XORs in the data word on every enabled cycle.
//  Ports    : clk    - clock
//             rst    - asynchronous reset, active-low
//             clr_i  - synchronous clear (wins over en_i)
//             en_i   - update enable
//             data_i - word folded into the signature
//             sig_o  - current signature
//  Revision : 1.0  initial release
// ============================================================================
module scan_misr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= '0;
        end else if (clr_i) begin
            sig_q <= '0;
        end else if (en_i) begin
            sig_q <= {sig_q[W-2:0], sig_q[W-1]} ^ data_i;
        end
    end

    assign sig_o = sig_q;

endmodule : scan_misr
`default_nettype wire

// File: rtl/scan_validator.sv
`default_nettype none
// ============================================================================
//  Module   : scan_validator
//  Purpose  : Scan-based validation wrapper between chip pins and a cipher
//             core. In IDLE the core is wired straight through to the pins.
//             In validation mode a stimulus vector is shifted in, applied to
//             the core for a bounded number of cycles (or until core_done),
//             and the result plus status flags are shifted back out.
//  Ports    : clk, rst (async, active-low)
//             begin_validate - validation enable (level; low aborts)
//             scan_en/scan_in/scan_out - serial chain, MSB first
//             run_cycles     - run timeout, 0 = wait for core_done forever
//             func_in/core_in, core_out/core_done, func_out/func_done
//             val_busy (LOAD/RUN), val_ready (HOLD)
//  Config   : SCAN_MISR_EN - capture an OUT_W-bit MISR signature of core_out
//             over the run instead of the final core_out word.
//  Revision : 1.0  initial release
// ============================================================================
module scan_validator
    import scan_val_pkg::*;
#(
    parameter int              IN_W       = 168,
    parameter int              OUT_W      = 32,
    parameter int              CNT_W      = 16,
    parameter logic [IN_W-1:0] PULSE_MASK = {3'b111, {(IN_W-3){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             begin_validate,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [IN_W-1:0]  func_in,
    output logic [IN_W-1:0]  core_in,
    input  logic [OUT_W-1:0] core_out,
    input  logic             core_done,
    output logic [OUT_W-1:0] func_out,
    output logic             func_done,
    output logic             val_busy,
    output logic             val_ready
);

    localparam int BC_W = $clog2(IN_W + 1);
    localparam int UC_W = $clog2(OUT_W + 3);
    localparam int OR_W = OUT_W + 2;

    localparam logic [BC_W-1:0] c_LAST_IN_BIT  = BC_W'(IN_W - 1);
    localparam logic [UC_W-1:0] c_LAST_OUT_BIT = UC_W'(OR_W - 1);
    localparam int              c_DONE_BIT     = OUT_W - 1 + DONE_OFS;
    localparam int              c_TMO_BIT      = OUT_W - 1 + TIMEOUT_OFS;

    scan_state_e       state_q, state_d;
    logic [IN_W-1:0]   in_reg_q;
    logic [BC_W-1:0]   bitcnt_q;
    logic [CNT_W-1:0]  run_cnt_q;
    logic [CNT_W-1:0]  run_lim_q;
    logic              first_q;
    logic [OR_W-1:0]   out_reg_q;
    logic [UC_W-1:0]   ucnt_q;
    logic              val_busy_q;
    logic              val_ready_q;

    logic              w_abort;
    logic              w_load_last;
    logic              w_run_tmo;
    logic              w_unload_last;
    logic [OUT_W-1:0]  w_cap_data;

    // Any non-IDLE state falls back to IDLE as soon as the enable drops.
    assign w_abort       = (state_q != S_IDLE) && !begin_validate;
    assign w_load_last   = scan_en && (bitcnt_q == c_LAST_IN_BIT);
    assign w_run_tmo     = (run_lim_q != '0) &&
                           (run_cnt_q == run_lim_q - CNT_W'(1));
    // The HOLD cycle already performs shift #1, so UNLOAD ends on the
    // shift where the counter reads OR_W-1.
    assign w_unload_last = scan_en && (ucnt_q == c_LAST_OUT_BIT);

`ifdef SCAN_MISR_EN
    logic [OUT_W-1:0] w_misr_sig;
    logic             w_misr_clr;
    logic             w_misr_en;

    // Cleared on the LOAD->RUN transition so the first RUN cycle folds
    // into a zero signature.
    assign w_misr_clr = (state_q == S_LOAD) && begin_validate && w_load_last;
    assign w_misr_en  = (state_q == S_RUN);

    scan_misr #(
        .W (OUT_W)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_misr_clr),
        .en_i   (w_misr_en),
        .data_i (core_out),
        .sig_o  (w_misr_sig)
    );

    assign w_cap_data = w_misr_sig;
`else
    assign w_cap_data = core_out;
`endif

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (w_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (begin_validate)          state_d = S_LOAD;
                S_LOAD:    if (w_load_last)             state_d = S_RUN;
                // core_done and timeout share the same exit; the flag
                // captured in CAPTURE records which one it was.
                S_RUN:     if (core_done || w_run_tmo)  state_d = S_CAPTURE;
                S_CAPTURE:                              state_d = S_HOLD;
                S_HOLD:    if (scan_en)                 state_d = S_UNLOAD;
                S_UNLOAD:  if (w_unload_last)           state_d = S_HOLD;
                default:                                state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, datapath and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_reg_q    <= '0;
            bitcnt_q    <= '0;
            run_cnt_q   <= '0;
            run_lim_q   <= '0;
            first_q     <= 1'b0;
            out_reg_q   <= '0;
            ucnt_q      <= '0;
            val_busy_q  <= 1'b0;
            val_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_busy_q  <= (state_d == S_LOAD) || (state_d == S_RUN);
            val_ready_q <= (state_d == S_HOLD);

            if (w_abort) begin
                in_reg_q  <= '0;
                out_reg_q <= '0;
                bitcnt_q  <= '0;
                run_cnt_q <= '0;
                first_q   <= 1'b0;
                ucnt_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (begin_validate) begin
                            in_reg_q <= '0;
                            bitcnt_q <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (scan_en) begin
                            in_reg_q <= {in_reg_q[IN_W-2:0], scan_in};
                            bitcnt_q <= bitcnt_q + BC_W'(1);
                            if (w_load_last) begin
                                run_lim_q <= run_cycles;
                                run_cnt_q <= '0;
                                first_q   <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        run_cnt_q <= run_cnt_q + CNT_W'(1);
                        first_q   <= 1'b0;
                    end
                    S_CAPTURE: begin
                        out_reg_q[OUT_W-1:0]  <= w_cap_data;
                        out_reg_q[c_DONE_BIT] <= core_done;
                        out_reg_q[c_TMO_BIT]  <= ~core_done;
                    end
                    S_HOLD: begin
                        if (scan_en) begin
                            out_reg_q <= {out_reg_q[OR_W-2:0], 1'b0};
                            ucnt_q    <= UC_W'(1);
                        end
                    end
                    S_UNLOAD: begin
                        if (scan_en) begin
                            out_reg_q <= {out_reg_q[OR_W-2:0], 1'b0};
                            ucnt_q    <= ucnt_q + UC_W'(1);
                        end
                    end
                    default: begin
                        in_reg_q <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output muxing
    // ------------------------------------------------------------------
    always_comb begin
        core_in = '0;
        case (state_q)
            S_IDLE:    core_in = func_in;
            // Strobe bits only survive the first RUN cycle.
            S_RUN:     core_in = in_reg_q & ~(PULSE_MASK & {IN_W{~first_q}});
            S_CAPTURE: core_in = in_reg_q & ~PULSE_MASK;
            default:   core_in = '0;
        endcase
    end

    assign func_out  = (state_q == S_IDLE) ? core_out  : '0;
    assign func_done = (state_q == S_IDLE) ? core_done : 1'b0;

    // The HOLD->UNLOAD cycle already presents the first result bit.
    assign scan_out  = ((state_q == S_HOLD) || (state_q == S_UNLOAD)) && scan_en
                       ? out_reg_q[OR_W-1] : 1'b0;

    assign val_busy  = val_busy_q;
    assign val_ready = val_ready_q;

endmodule : scan_validator
`default_nettype wire

// File: tb/tb_scan_validator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_validator
//  Purpose  : Scoreboard bench for scan_validator (IN_W=8, OUT_W=8,
//             CNT_W=8, PULSE_MASK=8'h80). Stimulus pushes masked expected
//             values of an observation word; a negedge monitor pops and
//             compares them.
//  Config   : SCAN_MISR_EN changes the expected data field of the MISR case.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_validator;

    localparam logic [31:0] M_CORE  = 32'h0000_00FF;
    localparam logic [31:0] M_FOUT  = 32'h0000_FF00;
    localparam logic [31:0] M_FDONE = 32'h0001_0000;
    localparam logic [31:0] M_SOUT  = 32'h0002_0000;
    localparam logic [31:0] M_BUSY  = 32'h0004_0000;
    localparam logic [31:0] M_RDY   = 32'h0008_0000;
    localparam logic [31:0] M_ALL   = 32'h000F_FFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       begin_validate;
    logic       scan_en;
    logic       scan_in;
    logic       scan_out;
    logic [7:0] run_cycles;
    logic [7:0] func_in;
    logic [7:0] core_in;
    logic [7:0] core_out;
    logic       core_done;
    logic [7:0] func_out;
    logic       func_done;
    logic       val_busy;
    logic       val_ready;

    scan_validator #(
        .IN_W       (8),
        .OUT_W      (8),
        .CNT_W      (8),
        .PULSE_MASK (8'h80)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .begin_validate (begin_validate),
        .scan_en        (scan_en),
        .scan_in        (scan_in),
        .scan_out       (scan_out),
        .run_cycles     (run_cycles),
        .func_in        (func_in),
        .core_in        (core_in),
        .core_out       (core_out),
        .core_done      (core_done),
        .func_out       (func_out),
        .func_done      (func_done),
        .val_busy       (val_busy),
        .val_ready      (val_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] mask;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] obs;

    assign obs = {12'd0, val_ready, val_busy, scan_out, func_done, func_out, core_in};

    // Monitor: every queued expectation refers to the current cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if ((obs & e.mask) !== e.val) begin
                fails++;
                $display("FAIL %s: got %h expected %h (mask %h)",
                         e.name, obs & e.mask, e.val, e.mask);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] m, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.mask = m;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic load(input logic [7:0] v, input bit gapped);
        logic [7:0] b;
        b = v;
        for (int i = 7; i >= 0; i--) begin
            scan_en = 1'b1;
            scan_in = b[i];
            step();
            if (gapped && i > 0) begin
                scan_en = 1'b0;
                chk("load_gap", M_BUSY | M_CORE, M_BUSY);
                step();
            end
        end
        scan_en = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && !val_ready; k++) step();
        tests++;
        if (val_ready !== 1'b1) begin
            fails++;
            $display("FAIL wait_ready: val_ready not seen within 50 cycles");
        end
        chk("wait_ready", M_RDY, M_RDY);
    endtask

    task automatic unload(input string n, input logic [9:0] bits);
        logic [9:0] b;
        b = bits;
        for (int i = 9; i >= 0; i--) begin
            scan_en = 1'b1;
            chk(n, M_SOUT, b[i] ? M_SOUT : 32'h0);
            step();
        end
        scan_en = 1'b0;
    endtask

    initial begin : stim
        logic [9:0] misr_exp;
        rst            = 1'b0;
        begin_validate = 1'b0;
        scan_en        = 1'b0;
        scan_in        = 1'b0;
        run_cycles     = 8'd0;
        func_in        = 8'hA5;
        core_out       = 8'h3C;
        core_done      = 1'b1;

        // Reset state + passthrough
        step();
        chk("reset_passthru", M_ALL, 32'h0001_3CA5);
        rst = 1'b1;
        step();
        func_in   = 8'h5A;
        core_out  = 8'hC3;
        core_done = 1'b0;
        chk("idle_passthru", M_ALL, 32'h0000_C35A);
        step();

        // Load C3, run until done on RUN cycle 4
        core_out       = 8'h00;
        run_cycles     = 8'd0;
        begin_validate = 1'b1;
        step();
        chk("load_outputs", M_ALL, M_BUSY);
        load(8'hC3, 1'b0);
        chk("run1_core_in", M_CORE | M_BUSY | M_FOUT, M_BUSY | 32'hC3);
        step();
        chk("run2_core_in", M_CORE | M_BUSY, M_BUSY | 32'h43);
        step();
        step();
        core_done = 1'b1;
        core_out  = 8'h5A;
        chk("run4_core_in", M_CORE | M_BUSY, M_BUSY | 32'h43);
        step();
        chk("capture_state", M_CORE | M_BUSY | M_RDY | M_FDONE, 32'h43);
        wait_ready();
        unload("unload_done", 10'b01_0101_1010);
        chk("hold_after_unload", M_RDY | M_BUSY, M_RDY);
        unload("unload_repeat", 10'b00_0000_0000);
        core_done      = 1'b0;
        begin_validate = 1'b0;
        step();
        chk("exit_idle", M_ALL, 32'h0000_5A5A);
        step();

        // Timeout after 5 RUN cycles
        core_out       = 8'hFF;
        run_cycles     = 8'd5;
        begin_validate = 1'b1;
        step();
        load(8'h0F, 1'b0);
        step(); step(); step(); step();
        chk("tmo_run5_busy", M_BUSY | M_RDY, M_BUSY);
        step();
        chk("tmo_capture", M_BUSY | M_RDY, 32'h0);
        wait_ready();
        unload("unload_tmo", 10'b10_1111_1111);
        begin_validate = 1'b0;
        step();

        // Gapped load, then abort mid-RUN
        core_out       = 8'h00;
        run_cycles     = 8'd0;
        begin_validate = 1'b1;
        step();
        load(8'hC3, 1'b1);
        chk("gap_run1_core_in", M_CORE | M_BUSY, M_BUSY | 32'hC3);
        step();
        chk("gap_run2_core_in", M_CORE | M_BUSY, M_BUSY | 32'h43);
        begin_validate = 1'b0;
        step();
        chk("abort_idle", M_ALL, 32'h0000_005A);
        step();

        // Reset mid-UNLOAD
        begin_validate = 1'b1;
        step();
        load(8'hA5, 1'b0);
        core_done = 1'b1;
        core_out  = 8'h81;
        step();
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            scan_en = 1'b1;
            chk("partial_unload", M_SOUT, (i == 0) ? 32'h0 : M_SOUT);
            step();
        end
        rst = 1'b0;
        #1;
        tests++;
        if ((obs & M_ALL) !== 32'h0001_815A) begin
            fails++;
            $display("FAIL reset_state: got %h expected %h", obs & M_ALL, 32'h0001_815A);
        end
        chk("async_reset", M_ALL, 32'h0001_815A);
        step();
        rst            = 1'b1;
        scan_en        = 1'b0;
        begin_validate = 1'b0;
        core_done      = 1'b0;
        step();

        // Two-cycle run: core_out 01 then 02 with done
        core_out       = 8'h00;
        begin_validate = 1'b1;
        step();
        load(8'h3C, 1'b0);
        core_out = 8'h01;
        step();
        core_out  = 8'h02;
        core_done = 1'b1;
        step();
        wait_ready();
`ifdef SCAN_MISR_EN
        misr_exp = 10'b01_0000_0000;
`else
        misr_exp = 10'b01_0000_0010;
`endif
        unload("unload_data_field", misr_exp);
        begin_validate = 1'b0;
        core_done      = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_scan_validator
`default_nettype wire
